// File: rtl/writeback_stage.sv
// ---------------------------------------------------------------------------
// writeback_stage
//
// Final pipeline stage. Holds the MEM/WB pipeline register, formats load
// data (byte/half-word select plus sign/zero extension), selects the
// writeback result and drives the register-file write port. result_w also
// serves as the WB forwarding source. The stage flags misaligned loads
// (which are suppressed and not retired) and keeps a 64-bit count of
// retired instructions.
//
// Ports
//   clk           in   rising-edge clock
//   rst_n         in   asynchronous, active-low reset
//   stall_w       in   hold the W register contents
//   flush_w       in   load a bubble into the W register (beats stall_w)
//   valid_m       in   M stage holds a real instruction
//   reg_write_m   in   instruction writes rd
//   res_src_m     in   00 ALU, 01 load, 10 pc+4, 11 immediate
//   funct3_m      in   load width/sign (LB/LH/LW/LBU/LHU)
//   rd_m          in   destination register
//   alu_result_m  in   ALU result / load byte address
//   read_data_m   in   raw word from data memory
//   pc_plus4_m    in   return address
//   imm_val_m     in   extended immediate
//   reg_write_w   out  register-file write enable
//   rd_w          out  register-file write address
//   result_w      out  register-file write data / forwarding value
//   misaligned_w  out  W instruction is a misaligned load
//   instret       out  retired-instruction count (wraps modulo 2^64)
// ---------------------------------------------------------------------------
module writeback_stage #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall_w,
  input  logic                     flush_w,
  input  logic                     valid_m,
  input  logic                     reg_write_m,
  input  logic [1:0]               res_src_m,
  input  logic [2:0]               funct3_m,
  input  logic [4:0]               rd_m,
  input  logic [DATA_WIDTH-1:0]    alu_result_m,
  input  logic [DATA_WIDTH-1:0]    read_data_m,
  input  logic [ADDRESS_WIDTH-1:0] pc_plus4_m,
  input  logic [DATA_WIDTH-1:0]    imm_val_m,
  output logic                     reg_write_w,
  output logic [4:0]               rd_w,
  output logic [DATA_WIDTH-1:0]    result_w,
  output logic                     misaligned_w,
  output logic [63:0]              instret
);

  localparam logic [1:0] SRC_ALU  = 2'b00;
  localparam logic [1:0] SRC_LOAD = 2'b01;
  localparam logic [1:0] SRC_PC4  = 2'b10;
  localparam logic [1:0] SRC_IMM  = 2'b11;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Select the addressed byte / half-word and extend it to full width.
  // Unlisted funct3 encodings pass the whole word through.
  function automatic logic [DATA_WIDTH-1:0] format_load(
    input logic [2:0]            funct3,
    input logic [1:0]            off,
    input logic [DATA_WIDTH-1:0] word
  );
    logic        [7:0]  byte_sel;
    logic        [15:0] half_sel;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    unique case (off)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = off[1] ? word[31:16] : word[15:0];
    byte_s   = $signed(byte_sel);
    half_s   = $signed(half_sel);
    case (funct3)
      F3_LB:   format_load = {{(DATA_WIDTH-8){byte_s[7]}}, byte_s};
      F3_LBU:  format_load = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
      F3_LH:   format_load = {{(DATA_WIDTH-16){half_s[15]}}, half_s};
      F3_LHU:  format_load = {{(DATA_WIDTH-16){1'b0}}, half_sel};
      default: format_load = word;
    endcase
  endfunction

  // Half-word loads need an even address, word loads a word-aligned one.
  function automatic logic load_misaligned(
    input logic [1:0] res_src,
    input logic [2:0] funct3,
    input logic [1:0] off
  );
    logic half_bad;
    logic word_bad;
    half_bad = ((funct3 == F3_LH) || (funct3 == F3_LHU)) && off[0];
    word_bad = (funct3 == F3_LW) && (off != 2'b00);
    load_misaligned = (res_src == SRC_LOAD) && (half_bad || word_bad);
  endfunction

  // W pipeline register
  logic                     valid_q,      valid_d;
  logic                     reg_write_q,  reg_write_d;
  logic [1:0]               res_src_q,    res_src_d;
  logic [2:0]               funct3_q,     funct3_d;
  logic [4:0]               rd_q,         rd_d;
  logic [DATA_WIDTH-1:0]    alu_result_q, alu_result_d;
  logic [DATA_WIDTH-1:0]    read_data_q,  read_data_d;
  logic [ADDRESS_WIDTH-1:0] pc_plus4_q,   pc_plus4_d;
  logic [DATA_WIDTH-1:0]    imm_val_q,    imm_val_d;
  logic [63:0]              instret_q,    instret_d;

  logic                     misaligned;
  logic                     retire;
  logic [DATA_WIDTH-1:0]    pc_ext;
  logic [DATA_WIDTH-1:0]    load_val;

  // Flush wins over stall. Only valid/reg_write matter for a bubble, so the
  // data fields simply hold to avoid needless toggling.
  always_comb begin
    valid_d      = valid_q;
    reg_write_d  = reg_write_q;
    res_src_d    = res_src_q;
    funct3_d     = funct3_q;
    rd_d         = rd_q;
    alu_result_d = alu_result_q;
    read_data_d  = read_data_q;
    pc_plus4_d   = pc_plus4_q;
    imm_val_d    = imm_val_q;
    if (flush_w) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
    end else if (!stall_w) begin
      valid_d      = valid_m;
      reg_write_d  = reg_write_m;
      res_src_d    = res_src_m;
      funct3_d     = funct3_m;
      rd_d         = rd_m;
      alu_result_d = alu_result_m;
      read_data_d  = read_data_m;
      pc_plus4_d   = pc_plus4_m;
      imm_val_d    = imm_val_m;
    end
  end

  // A held instruction retires only on the edge where it leaves W, so the
  // count advances only when stall_w is low.
  assign retire    = valid_q & ~stall_w & ~misaligned;
  assign instret_d = retire ? instret_q + 64'd1 : instret_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      res_src_q    <= '0;
      funct3_q     <= '0;
      rd_q         <= '0;
      alu_result_q <= '0;
      read_data_q  <= '0;
      pc_plus4_q   <= '0;
      imm_val_q    <= '0;
      instret_q    <= '0;
    end else begin
      valid_q      <= valid_d;
      reg_write_q  <= reg_write_d;
      res_src_q    <= res_src_d;
      funct3_q     <= funct3_d;
      rd_q         <= rd_d;
      alu_result_q <= alu_result_d;
      read_data_q  <= read_data_d;
      pc_plus4_q   <= pc_plus4_d;
      imm_val_q    <= imm_val_d;
      instret_q    <= instret_d;
    end
  end

  // Writeback result selection (combinational from the W register)
  if (ADDRESS_WIDTH >= DATA_WIDTH) begin : g_pc_trunc
    assign pc_ext = pc_plus4_q[DATA_WIDTH-1:0];
  end else begin : g_pc_zext
    assign pc_ext = {{(DATA_WIDTH-ADDRESS_WIDTH){1'b0}}, pc_plus4_q};
  end

  assign load_val   = format_load(funct3_q, alu_result_q[1:0], read_data_q);
  assign misaligned = valid_q & load_misaligned(res_src_q, funct3_q, alu_result_q[1:0]);

  always_comb begin
    result_w = alu_result_q;
    unique case (res_src_q)
      SRC_ALU:  result_w = alu_result_q;
      SRC_LOAD: result_w = load_val;
      SRC_PC4:  result_w = pc_ext;
      SRC_IMM:  result_w = imm_val_q;
      default:  result_w = alu_result_q;
    endcase
  end

  assign reg_write_w  = valid_q & reg_write_q & (rd_q != 5'd0) & ~misaligned;
  assign rd_w         = rd_q;
  assign misaligned_w = misaligned;
  assign instret      = instret_q;

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

  logic        clk;
  logic        rst_n;
  logic        stall_w;
  logic        flush_w;
  logic        valid_m;
  logic        reg_write_m;
  logic [1:0]  res_src_m;
  logic [2:0]  funct3_m;
  logic [4:0]  rd_m;
  logic [31:0] alu_result_m;
  logic [31:0] read_data_m;
  logic [31:0] pc_plus4_m;
  logic [31:0] imm_val_m;
  logic        reg_write_w;
  logic [4:0]  rd_w;
  logic [31:0] result_w;
  logic        misaligned_w;
  logic [63:0] instret;

  int errors = 0;
  int checks = 0;

  // Reference model of the instruction sitting in W
  logic        mv, mrw;
  logic [1:0]  msrc;
  logic [2:0]  mf3;
  logic [4:0]  mrd;
  logic [31:0] malu, mdata, mpc, mimm;
  logic [63:0] minst;

  writeback_stage #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_w      (stall_w),
    .flush_w      (flush_w),
    .valid_m      (valid_m),
    .reg_write_m  (reg_write_m),
    .res_src_m    (res_src_m),
    .funct3_m     (funct3_m),
    .rd_m         (rd_m),
    .alu_result_m (alu_result_m),
    .read_data_m  (read_data_m),
    .pc_plus4_m   (pc_plus4_m),
    .imm_val_m    (imm_val_m),
    .reg_write_w  (reg_write_w),
    .rd_w         (rd_w),
    .result_w     (result_w),
    .misaligned_w (misaligned_w),
    .instret      (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Load formatting from the ISA rules: shift the word down by the byte
  // offset, mask, and extend by arithmetic on the value.
  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] word);
    int unsigned off;
    logic [31:0] b, h;
    off = addr % 4;
    b = (word >> (8 * off)) & 32'hFF;
    h = (word >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128)   ? b - 32'd256   : b;
      3'd4:    return b;
      3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'd5:    return h;
      default: return word;
    endcase
  endfunction

  function automatic logic model_mis();
    logic half_op, word_op;
    half_op = (mf3 == 3'd1) || (mf3 == 3'd5);
    word_op = (mf3 == 3'd2);
    return mv && (msrc == 2'd1) &&
           ((half_op && (malu % 2 != 0)) || (word_op && (malu % 4 != 0)));
  endfunction

  function automatic logic [31:0] model_result();
    case (msrc)
      2'd0:    return malu;
      2'd1:    return exp_load(mf3, malu, mdata);
      2'd2:    return mpc;
      default: return mimm;
    endcase
  endfunction

  task automatic model_reset();
    mv = 0; mrw = 0; msrc = 0; mf3 = 0; mrd = 0;
    malu = 0; mdata = 0; mpc = 0; mimm = 0; minst = 0;
  endtask

  // Applies one clock edge to the model using the inputs seen at that edge.
  task automatic model_edge();
    if (mv && !stall_w && !model_mis()) minst = minst + 64'd1;
    if (flush_w) begin
      mv = 0; mrw = 0;
    end else if (!stall_w) begin
      mv = valid_m; mrw = reg_write_m; msrc = res_src_m; mf3 = funct3_m; mrd = rd_m;
      malu = alu_result_m; mdata = read_data_m; mpc = pc_plus4_m; mimm = imm_val_m;
    end
  endtask

  task automatic check_model();
    logic mis;
    mis = model_mis();
    chk("reg_write_w", 64'(reg_write_w), 64'(mv && mrw && (mrd != 0) && !mis));
    chk("misaligned_w", 64'(misaligned_w), 64'(mis));
    chk("instret", instret, minst);
    if (mv) begin
      chk("rd_w", 64'(rd_w), 64'(mrd));
      chk("result_w", 64'(result_w), 64'(model_result()));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic drive(input logic v, input logic rw, input logic [1:0] src, input logic [2:0] f3,
                       input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] data,
                       input logic [31:0] pc, input logic [31:0] imm);
    valid_m = v; reg_write_m = rw; res_src_m = src; funct3_m = f3; rd_m = rd;
    alu_result_m = alu; read_data_m = data; pc_plus4_m = pc; imm_val_m = imm;
  endtask

  initial begin
    logic [2:0] f3_tab [7];
    f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6};

    rst_n = 0; stall_w = 0; flush_w = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model();
    chk("reset rd_w", 64'(rd_w), 64'd0);
    chk("reset result_w", 64'(result_w), 64'd0);
    rst_n = 1;

    // LW aligned
    drive(1, 1, 2'b01, 3'b010, 5'd5, 32'h100, 32'hDEADBEEF, 0, 0);
    cycle();
    chk("lw reg_write", 64'(reg_write_w), 64'd1);
    chk("lw rd", 64'(rd_w), 64'd5);
    chk("lw result", 64'(result_w), 64'hDEADBEEF);
    chk("lw instret before", instret, 64'd0);

    drive(1, 1, 2'b01, 3'b000, 5'd6, 32'h103, 32'h80FF1234, 0, 0);
    cycle();
    chk("lw instret after", instret, 64'd1);
    chk("lb result", 64'(result_w), 64'hFFFFFF80);

    drive(1, 1, 2'b01, 3'b100, 5'd6, 32'h103, 32'h80FF1234, 0, 0);
    cycle();
    chk("lbu result", 64'(result_w), 64'h00000080);

    drive(1, 1, 2'b01, 3'b101, 5'd8, 32'h102, 32'hBEEF0000, 0, 0);
    cycle();
    chk("lhu result", 64'(result_w), 64'h0000BEEF);

    drive(1, 1, 2'b01, 3'b001, 5'd9, 32'h101, 32'hBEEF0000, 0, 0);
    cycle();
    chk("lh misaligned", 64'(misaligned_w), 64'd1);
    chk("lh no write", 64'(reg_write_w), 64'd0);
    chk("lh instret", instret, 64'd4);

    // ALU to x0
    drive(1, 1, 2'b00, 3'b000, 5'd0, 32'h55, 0, 0, 0);
    cycle();
    chk("x0 no write", 64'(reg_write_w), 64'd0);
    chk("x0 result", 64'(result_w), 64'h55);
    chk("misaligned not retired", instret, 64'd4);

    // Stall three cycles, then flush+stall together
    drive(1, 1, 2'b00, 3'b000, 5'd7, 32'h77, 0, 0, 0);
    cycle();
    chk("x0 retired", instret, 64'd5);
    stall_w = 1;
    drive(1, 1, 2'b11, 3'b000, 5'd12, 32'h99, 0, 0, 32'hAAAA);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall rd held", 64'(rd_w), 64'd7);
      chk("stall result held", 64'(result_w), 64'h77);
      chk("stall instret", instret, 64'd5);
    end
    flush_w = 1;
    cycle();
    chk("flush no write", 64'(reg_write_w), 64'd0);
    chk("flush instret", instret, 64'd5);
    flush_w = 0; stall_w = 0;

    // JAL then LUI
    drive(1, 1, 2'b10, 3'b000, 5'd1, 32'h0, 0, 32'h204, 0);
    cycle();
    chk("jal result", 64'(result_w), 64'h204);
    drive(1, 1, 2'b11, 3'b000, 5'd2, 32'h0, 0, 0, 32'h12345000);
    cycle();
    chk("lui result", 64'(result_w), 64'h12345000);
    chk("jal retired", instret, 64'd6);

    // Asynchronous reset mid-cycle
    #2;
    rst_n = 0;
    #1;
    chk("async reg_write", 64'(reg_write_w), 64'd0);
    chk("async rd", 64'(rd_w), 64'd0);
    chk("async result", 64'(result_w), 64'd0);
    chk("async misaligned", 64'(misaligned_w), 64'd0);
    chk("async instret", instret, 64'd0);
    model_reset();
    #1;
    rst_n = 1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      stall_w = ($urandom_range(0, 4) == 0);
      flush_w = ($urandom_range(0, 9) == 0);
      drive($urandom_range(0, 5) != 0, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
            f3_tab[$urandom_range(0, 6)], 5'($urandom_range(0, 31)), $urandom, $urandom,
            $urandom, $urandom);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
